// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises per-LSU read/write requests onto one shared data-memory channel.
// Define MEM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority (lowest index wins).
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                 state_q, state_d;
    logic [IDX_BITS-1:0]    grant_q, grant_d;
    logic [IDX_BITS-1:0]    scan_base;
    logic                   mem_rvalid_q, mem_rvalid_d;
    logic [ADDR_BITS-1:0]   mem_raddr_q, mem_raddr_d;
    logic                   mem_wvalid_q, mem_wvalid_d;
    logic [ADDR_BITS-1:0]   mem_waddr_q, mem_waddr_d;
    logic [DATA_BITS-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NUM_CONSUMERS-1:0] rready_q, rready_d;
    logic [NUM_CONSUMERS-1:0] wready_q, wready_d;
    logic [DATA_BITS-1:0]   rdata_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   rdata_d [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]   rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]   wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   wr_data [NUM_CONSUMERS];
    logic                   sel_found;
    logic [IDX_BITS-1:0]    sel_idx;
    logic                   relay_valid;
    int                     scan_idx;

    generate
        for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_port
            assign rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_q[gi];
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    assign scan_base = ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign scan_base = '0;
`endif

    // First requester at or after scan_base, wrapping modulo NUM_CONSUMERS.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan_idx = (int'(scan_base) + k) % NUM_CONSUMERS;
            if (!sel_found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
                sel_found = 1'b1;
                sel_idx   = IDX_BITS'(scan_idx);
            end
        end
    end

    // In RELAY the held ready tells which of the granted consumer's valids to watch.
    assign relay_valid = rready_q[grant_q] ? consumer_read_valid[grant_q]
                                           : consumer_write_valid[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        mem_rvalid_d = mem_rvalid_q;
        mem_raddr_d  = mem_raddr_q;
        mem_wvalid_d = mem_wvalid_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        rready_d     = rready_q;
        wready_d     = wready_q;
        rdata_d      = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    if (consumer_read_valid[sel_idx]) begin
                        mem_rvalid_d = 1'b1;
                        mem_raddr_d  = rd_addr[sel_idx];
                        state_d      = READ_WAIT;
                    end else begin
                        mem_wvalid_d = 1'b1;
                        mem_waddr_d  = wr_addr[sel_idx];
                        mem_wdata_d  = wr_data[sel_idx];
                        state_d      = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    rdata_d[grant_q]  = mem_read_data;
                    rready_d[grant_q] = 1'b1;
                    mem_rvalid_d      = 1'b0;
                    state_d           = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    wready_d[grant_q] = 1'b1;
                    mem_wvalid_d      = 1'b0;
                    state_d           = RELAY;
                end
            end
            RELAY: begin
                if (!relay_valid) begin
                    rready_d[grant_q] = 1'b0;
                    wready_d[grant_q] = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d = (grant_q == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            mem_rvalid_q <= 1'b0;
            mem_raddr_q  <= '0;
            mem_wvalid_q <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            rready_q     <= '0;
            wready_q     <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_raddr_q  <= mem_raddr_d;
            mem_wvalid_q <= mem_wvalid_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            rready_q     <= rready_d;
            wready_q     <= wready_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_read_valid       = mem_rvalid_q;
    assign mem_read_address     = mem_raddr_q;
    assign mem_write_valid      = mem_wvalid_q;
    assign mem_write_address    = mem_waddr_q;
    assign mem_write_data       = mem_wdata_q;
    assign consumer_read_ready  = rready_q;
    assign consumer_write_ready = wready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level reference model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    rv, wv;
    logic [AW-1:0]   ra [N];
    logic [AW-1:0]   wa [N];
    logic [DW-1:0]   wd [N];
    logic [N*AW-1:0] ra_bus, wa_bus;
    logic [N*DW-1:0] wd_bus;
    logic [N-1:0]    consumer_read_ready, consumer_write_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid, mem_read_ready;
    logic [AW-1:0]   mem_read_address;
    logic [DW-1:0]   mem_read_data;
    logic            mem_write_valid, mem_write_ready;
    logic [AW-1:0]   mem_write_address;
    logic [DW-1:0]   mem_write_data;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign ra_bus[gi*AW +: AW] = ra[gi];
            assign wa_bus[gi*AW +: AW] = wa[gi];
            assign wd_bus[gi*DW +: DW] = wd[gi];
        end
    endgenerate

    mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (ra_bus),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (wv),
        .consumer_write_address (wa_bus),
        .consumer_write_data    (wd_bus),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    logic [DW-1:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = arbiter free, 1 = memory request outstanding, 2 = completion held.
    int            m_stage = 0;
    int            m_gnt   = 0;
    int            m_ptr   = 0;
    bit            m_rd    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] exp_rdata [N];
    bit            gen_en    = 1'b0;
    int            lat_fixed = -1;
    int            wait_left = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int base;
        int w;
        bit found;
        if (!reset) begin
            m_stage = 0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) exp_rdata[i] = '0;
            return;
        end
        case (m_stage)
            0: begin
                if ((rv | wv) != '0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    base = m_ptr;
`else
                    base = 0;
`endif
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        w = (base + k) % N;
                        if (!found && (rv[w] || wv[w])) begin
                            found = 1'b1;
                            m_gnt = w;
                        end
                    end
                    m_rd    = rv[m_gnt];
                    m_addr  = m_rd ? ra[m_gnt] : wa[m_gnt];
                    m_data  = wd[m_gnt];
                    m_stage = 1;
                end
            end
            1: begin
                if (m_rd ? mem_read_ready : mem_write_ready) begin
                    if (m_rd) exp_rdata[m_gnt] = mem[m_addr];
                    $display("[TB] txn consumer %0d %s addr=%02h data=%02h", m_gnt,
                             m_rd ? "read " : "write", m_addr, m_rd ? mem[m_addr] : m_data);
                    m_stage = 2;
                end
            end
            default: begin
                if (!(m_rd ? rv[m_gnt] : wv[m_gnt])) begin
                    m_stage = 0;
                    m_ptr   = (m_gnt + 1) % N;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_wr;
        exp_rr = '0;
        exp_wr = '0;
        if (m_stage == 2 && m_rd)  exp_rr[m_gnt] = 1'b1;
        if (m_stage == 2 && !m_rd) exp_wr[m_gnt] = 1'b1;
        check_eq("mem_rd_valid", 32'(mem_read_valid), 32'(m_stage == 1 && m_rd));
        check_eq("mem_wr_valid", 32'(mem_write_valid), 32'(m_stage == 1 && !m_rd));
        check_eq("rd_ready", 32'(consumer_read_ready), 32'(exp_rr));
        check_eq("wr_ready", 32'(consumer_write_ready), 32'(exp_wr));
        for (int i = 0; i < N; i++)
            check_eq($sformatf("rd_data%0d", i), 32'(consumer_read_data[i*DW +: DW]), 32'(exp_rdata[i]));
        if (!reset) begin
            check_eq("rst_rd_addr", 32'(mem_read_address), 32'(0));
            check_eq("rst_wr_addr", 32'(mem_write_address), 32'(0));
            check_eq("rst_wr_data", 32'(mem_write_data), 32'(0));
        end else if (m_stage == 1 && m_rd) begin
            check_eq("mem_rd_addr", 32'(mem_read_address), 32'(m_addr));
        end else if (m_stage == 1) begin
            check_eq("mem_wr_addr", 32'(mem_write_address), 32'(m_addr));
            check_eq("mem_wr_data", 32'(mem_write_data), 32'(m_data));
        end
    endtask

    // Memory responder plus LSU behaviour; runs on the falling edge.
    task automatic drive();
        bit busy;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = DW'($urandom);
        if (mem_read_valid || mem_write_valid) begin
            if (wait_left <= 0) begin
                if (mem_read_valid) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem[mem_read_address];
                end else begin
                    mem_write_ready = 1'b1;
                    mem[mem_write_address] = mem_write_data;
                end
                wait_left = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
            end else begin
                wait_left--;
            end
        end else begin
            wait_left = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
        end

        reset = 1'b1;
        if (gen_en && m_stage == 1 && $urandom_range(0, 39) == 0) begin
            reset = 1'b0;
            rv = '0;
            wv = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            busy = (m_stage != 0) && (m_gnt == i);
            if (consumer_read_ready[i] && rv[i] && $urandom_range(0, 3) != 0) rv[i] = 1'b0;
            if (consumer_write_ready[i] && wv[i] && $urandom_range(0, 3) != 0) wv[i] = 1'b0;
            if (m_stage == 1 && m_gnt == i) begin
                if ($urandom_range(0, 1) == 1) begin
                    ra[i] = AW'($urandom);
                    wa[i] = AW'($urandom);
                    wd[i] = DW'($urandom);
                end
                if (gen_en && $urandom_range(0, 15) == 0) begin
                    if (m_rd) rv[i] = 1'b0;
                    else      wv[i] = 1'b0;
                end
            end
            if (gen_en && !busy) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom);
                end
                if (!wv[i] && $urandom_range(0, 3) == 0) begin
                    wv[i] = 1'b1;
                    wa[i] = AW'($urandom);
                    wd[i] = DW'($urandom);
                end
            end
        end
    endtask

    task automatic step(input bit do_drive);
        @(negedge clk);
        if (do_drive) drive();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic run_drain();
        int guard;
        guard = 0;
        step(1'b1);
        while (!(m_stage == 0 && (rv | wv) == '0) && guard < 300) begin
            step(1'b1);
            guard++;
        end
        check_eq("drain_timeout", 32'(rv | wv), 32'(0));
    endtask

    initial begin
        reset           = 1'b0;
        rv              = '1;
        wv              = '1;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[8'h1A] = 8'h5C;
        for (int i = 0; i < N; i++) begin
            ra[i] = AW'($urandom);
            wa[i] = AW'($urandom);
            wd[i] = DW'($urandom);
            exp_rdata[i] = '0;
        end

        // Reset held with every request asserted, then released: consumer 0 reads first.
        repeat (3) step(1'b0);
        run_drain();

        // Single read from consumer 2 with three memory wait cycles.
        lat_fixed = 3;
        rv[2] = 1'b1;
        ra[2] = 8'h1A;
        run_drain();

        // Single write from consumer 1.
        lat_fixed = 0;
        wv[1] = 1'b1;
        wa[1] = 8'h40;
        wd[1] = 8'hA5;
        run_drain();
        check_eq("write_landed", 32'(mem[8'h40]), 32'(8'hA5));

        // All four consumers read at once.
        lat_fixed = -1;
        rv = '1;
        for (int i = 0; i < N; i++) ra[i] = AW'(8'h10 + i);
        run_drain();

        // Consumer 3 asserts read and write together.
        rv[3] = 1'b1;
        ra[3] = 8'h33;
        wv[3] = 1'b1;
        wa[3] = 8'h77;
        wd[3] = 8'h3C;
        run_drain();

        // Randomised traffic with occasional mid-transaction reset.
        gen_en = 1'b1;
        repeat (3000) step(1'b1);
        gen_en = 1'b0;
        run_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates memory requests from NUM_CONSUMERS per-thread load/store units onto one shared data-memory channel. Sits directly downstream of the LSUs, between the per-thread valid/ready request ports and the external data memory. Serialises one transaction at a time, relays read data and completion back to the granted LSU, and holds completion until that LSU withdraws its request.

## Interface
- NUM_CONSUMERS, 4: number of LSU request ports (≥2).
- ADDR_BITS, 8: address width.
- DATA_BITS, 8: data width.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clk.
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  output  NUM_CONSUMERS  per-LSU read completion.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data.
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed.
- consumer_write_ready  output  NUM_CONSUMERS  per-LSU write completion.
- mem_read_valid / mem_read_address  output  1 / ADDR_BITS  memory read request.
- mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read completion, data valid with ready.
- mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  memory write request.
- mem_write_ready  input  1  memory write completion.

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY. Registers: grant index, rr pointer (clog2(NUM_CONSUMERS) bits).
- Reset (reset=0): state IDLE, pointer 0, grant 0; all valid/ready outputs 0; all address/data outputs 0.
- IDLE: scan consumers starting at pointer, wrapping modulo NUM_CONSUMERS; first i with read_valid or write_valid wins. If both set on i, read wins. Read: latch address into mem_read_address, mem_read_valid←1, → READ_WAIT. Write: latch address/data, mem_write_valid←1, → WRITE_WAIT. No request: stay.
- READ_WAIT: on mem_read_ready=1: consumer_read_data[grant]←mem_read_data, consumer_read_ready[grant]←1, mem_read_valid←0, → RELAY.
- WRITE_WAIT: on mem_write_ready=1: consumer_write_ready[grant]←1, mem_write_valid←0, → RELAY.
- RELAY: when granted consumer's corresponding valid is 0: its ready←0, pointer←(grant+1) mod N, → IDLE. Else hold.
- Requests are not abortable: consumer valid dropping in *_WAIT is ignored; memory transaction completes, ready then pulses ≥1 cycle in RELAY.
- Address/data are sampled only at grant; later changes by consumer are ignored.
- consumer_read_data[i] holds last value until overwritten by next read grant to i.
- At most one consumer ready bit and one mem valid bit high at any time.

## Timing
- Grant: request sampled in IDLE at edge E0 → mem_*_valid high after E0.
- Memory ready sampled at edge E1 → consumer ready/data visible after E1, mem valid low after E1.
- Registered-valid LSU drops valid at E2; arbiter sees it at E3 → ready low, IDLE after E3; next grant earliest at E4.
- Minimum occupancy per transaction with zero-wait memory (ready high in first WAIT cycle): 4 cycles IDLE-to-IDLE.
- Reset mid-transaction: all outputs clear next edge; in-flight memory request abandoned, no completion delivered.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: rotating priority as above, pointer advances past last served consumer.
- Undefined: fixed priority, scan always starts at consumer 0; pointer register not implemented (lowest index wins).

## Test plan
- Reset: hold reset=0 3 cycles with all valids high → all outputs 0, state IDLE; release → consumer 0 granted first.
- Single read: consumer 2 read addr 0x1A, memory returns 0x5C after 3 wait cycles → mem_read_address=0x1A, consumer_read_ready[2]=1 with data 0x5C, held until valid[2] drops.
- Single write: consumer 1 write addr 0x40 data 0xA5 → mem_write_* = 0x40/0xA5 one request, consumer_write_ready[1] pulses, mem_write_valid low thereafter.
- Contention: consumers 0–3 all read simultaneously → with _EN grants 0,1,2,3 in order; without _EN consumer 0 re-requesting immediately starves 1.
- Read/write same consumer: consumer 3 asserts both → read served first, then write on a later grant.
- Reset mid-transaction: reset=0 in READ_WAIT → mem_read_valid and all ready bits 0 next edge, pointer 0.
